// File: rtl/issue_queue.sv
// issue_queue: unified out-of-order issue queue for add/mul micro-ops.
//
// Purpose:
//   Collapsing queue. Slots 0..count-1 are valid and slot 0 is the oldest.
//   Source readiness is tracked by snooping the add and mul writeback tags.
//   Each cycle the oldest ready add and the oldest ready mul are selected.
//   They issue into registered output ports.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   valid_dispatch .. tag_ROB_in   incoming renamed micro-op
//   freeze_front             block dispatch acceptance
//   freeze_back              hold issue outputs and slot membership
//   valid_Result_*/tag_PRF_* writeback wakeup ports
//   full_IQ                  registered count == DEPTH
//   *_add / *_mul outputs    registered issue ports, one per class
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int PRF_W = 5,
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_dispatch,
  input  logic             op_mul,
  input  logic [PRF_W-1:0] tag_Ra_in,
  input  logic [PRF_W-1:0] tag_Rb_in,
  input  logic             rdy_a_in,
  input  logic             rdy_b_in,
  input  logic [PRF_W-1:0] tag_PRF_in,
  input  logic [ROB_W-1:0] tag_ROB_in,
  input  logic             freeze_front,
  input  logic             freeze_back,
  input  logic             valid_Result_add,
  input  logic [PRF_W-1:0] tag_PRF_add,
  input  logic             valid_Result_mul,
  input  logic [PRF_W-1:0] tag_PRF_mul,
  output logic             full_IQ,
  output logic             valid_add,
  output logic [PRF_W-1:0] tag_Ra_add,
  output logic [PRF_W-1:0] tag_Rb_add,
  output logic [PRF_W-1:0] tag_PRF_add_out,
  output logic [ROB_W-1:0] tag_ROB_add_out,
  output logic             valid_mul,
  output logic [PRF_W-1:0] tag_Ra_mul,
  output logic [PRF_W-1:0] tag_Rb_mul,
  output logic [PRF_W-1:0] tag_PRF_mul_out,
  output logic [ROB_W-1:0] tag_ROB_mul_out
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic             op;
    logic [PRF_W-1:0] ra;
    logic [PRF_W-1:0] rb;
    logic             rdy_a;
    logic             rdy_b;
    logic [PRF_W-1:0] prf;
    logic [ROB_W-1:0] rob;
  } entry_t;

  entry_t           r_slot [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_full;

  logic             r_valid_add;
  logic [PRF_W-1:0] r_ra_add;
  logic [PRF_W-1:0] r_rb_add;
  logic [PRF_W-1:0] r_prf_add;
  logic [ROB_W-1:0] r_rob_add;
  logic             r_valid_mul;
  logic [PRF_W-1:0] r_ra_mul;
  logic [PRF_W-1:0] r_rb_mul;
  logic [PRF_W-1:0] r_prf_mul;
  logic [ROB_W-1:0] r_rob_mul;

  logic             w_add_hit;
  logic [IW-1:0]    w_add_idx;
  logic             w_mul_hit;
  logic [IW-1:0]    w_mul_idx;
  logic             w_rm_add;
  logic             w_rm_mul;
  logic             w_accept;
  logic [DEPTH-1:0] w_gone;
  entry_t           w_surv;
  entry_t           w_new;
  entry_t           w_nxt_slot [DEPTH];
  logic [CW-1:0]    w_k;

  function automatic logic wake(input logic [PRF_W-1:0] t,
                                input logic va, input logic [PRF_W-1:0] ta,
                                input logic vm, input logic [PRF_W-1:0] tm);
    return (va && (t == ta)) || (vm && (t == tm));
  endfunction

  // Select uses only registered readiness, so entries dispatched or woken
  // this cycle wait one cycle. Scanning downward leaves the lowest index.
  always_comb begin
    w_add_hit = 1'b0;
    w_add_idx = '0;
    w_mul_hit = 1'b0;
    w_mul_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CW'(i) < r_count) && r_slot[i].rdy_a && r_slot[i].rdy_b) begin
        if (r_slot[i].op) begin
          w_mul_hit = 1'b1;
          w_mul_idx = IW'(i);
        end else begin
          w_add_hit = 1'b1;
          w_add_idx = IW'(i);
        end
      end
    end
  end

  assign w_rm_add = w_add_hit & ~freeze_back;
  assign w_rm_mul = w_mul_hit & ~freeze_back;
  assign w_accept = valid_dispatch & ~freeze_front & ~r_full;

  always_comb begin
    w_gone = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_gone[i] = (w_rm_add && (w_add_idx == IW'(i))) ||
                  (w_rm_mul && (w_mul_idx == IW'(i)));
    end
  end

  // Compact the survivors toward slot 0 and apply wakeup to them. Then
  // append the accepted entry, which also sees this cycle's wakeup tags.
  always_comb begin
    w_nxt_slot = r_slot;
    w_surv     = '0;
    w_new      = '0;
    w_k        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_surv       = r_slot[i];
      w_surv.rdy_a = r_slot[i].rdy_a | wake(r_slot[i].ra, valid_Result_add, tag_PRF_add,
                                            valid_Result_mul, tag_PRF_mul);
      w_surv.rdy_b = r_slot[i].rdy_b | wake(r_slot[i].rb, valid_Result_add, tag_PRF_add,
                                            valid_Result_mul, tag_PRF_mul);
      if ((CW'(i) < r_count) && !w_gone[i]) begin
        w_nxt_slot[w_k[IW-1:0]] = w_surv;
        w_k = w_k + CW'(1);
      end
    end
    w_new.op    = op_mul;
    w_new.ra    = tag_Ra_in;
    w_new.rb    = tag_Rb_in;
    w_new.rdy_a = rdy_a_in | wake(tag_Ra_in, valid_Result_add, tag_PRF_add,
                                  valid_Result_mul, tag_PRF_mul);
    w_new.rdy_b = rdy_b_in | wake(tag_Rb_in, valid_Result_add, tag_PRF_add,
                                  valid_Result_mul, tag_PRF_mul);
    w_new.prf   = tag_PRF_in;
    w_new.rob   = tag_ROB_in;
    // A queue that is not full always has room past the survivors.
    if (w_accept) begin
      w_nxt_slot[w_k[IW-1:0]] = w_new;
      w_k = w_k + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_valid_add <= 1'b0;
      r_ra_add    <= '0;
      r_rb_add    <= '0;
      r_prf_add   <= '0;
      r_rob_add   <= '0;
      r_valid_mul <= 1'b0;
      r_ra_mul    <= '0;
      r_rb_mul    <= '0;
      r_prf_mul   <= '0;
      r_rob_mul   <= '0;
    end else begin
      r_slot  <= w_nxt_slot;
      r_count <= w_k;
      r_full  <= (w_k == CW'(DEPTH));
      if (!freeze_back) begin
        r_valid_add <= w_add_hit;
        r_valid_mul <= w_mul_hit;
        // A class without a winner keeps its last tags.
        if (w_add_hit) begin
          r_ra_add  <= r_slot[w_add_idx].ra;
          r_rb_add  <= r_slot[w_add_idx].rb;
          r_prf_add <= r_slot[w_add_idx].prf;
          r_rob_add <= r_slot[w_add_idx].rob;
        end
        if (w_mul_hit) begin
          r_ra_mul  <= r_slot[w_mul_idx].ra;
          r_rb_mul  <= r_slot[w_mul_idx].rb;
          r_prf_mul <= r_slot[w_mul_idx].prf;
          r_rob_mul <= r_slot[w_mul_idx].rob;
        end
      end
    end
  end

  assign full_IQ         = r_full;
  assign valid_add       = r_valid_add;
  assign tag_Ra_add      = r_ra_add;
  assign tag_Rb_add      = r_rb_add;
  assign tag_PRF_add_out = r_prf_add;
  assign tag_ROB_add_out = r_rob_add;
  assign valid_mul       = r_valid_mul;
  assign tag_Ra_mul      = r_ra_mul;
  assign tag_Rb_mul      = r_rb_mul;
  assign tag_PRF_mul_out = r_prf_mul;
  assign tag_ROB_mul_out = r_rob_mul;

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed vectors plus hand-written multi-cycle sequences
// for issue_queue with the default parameters (DEPTH=8, PRF_W=5, ROB_W=4).
module tb_issue_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_dispatch, op_mul;
  logic [4:0] tag_Ra_in, tag_Rb_in, tag_PRF_in;
  logic       rdy_a_in, rdy_b_in;
  logic [3:0] tag_ROB_in;
  logic       freeze_front, freeze_back;
  logic       valid_Result_add, valid_Result_mul;
  logic [4:0] tag_PRF_add, tag_PRF_mul;
  logic       full_IQ, valid_add, valid_mul;
  logic [4:0] tag_Ra_add, tag_Rb_add, tag_PRF_add_out;
  logic [4:0] tag_Ra_mul, tag_Rb_mul, tag_PRF_mul_out;
  logic [3:0] tag_ROB_add_out, tag_ROB_mul_out;

  int n_pass  = 0;
  int n_total = 0;

  issue_queue dut (
    .clk(clk), .rst(rst),
    .valid_dispatch(valid_dispatch), .op_mul(op_mul),
    .tag_Ra_in(tag_Ra_in), .tag_Rb_in(tag_Rb_in),
    .rdy_a_in(rdy_a_in), .rdy_b_in(rdy_b_in),
    .tag_PRF_in(tag_PRF_in), .tag_ROB_in(tag_ROB_in),
    .freeze_front(freeze_front), .freeze_back(freeze_back),
    .valid_Result_add(valid_Result_add), .tag_PRF_add(tag_PRF_add),
    .valid_Result_mul(valid_Result_mul), .tag_PRF_mul(tag_PRF_mul),
    .full_IQ(full_IQ),
    .valid_add(valid_add), .tag_Ra_add(tag_Ra_add), .tag_Rb_add(tag_Rb_add),
    .tag_PRF_add_out(tag_PRF_add_out), .tag_ROB_add_out(tag_ROB_add_out),
    .valid_mul(valid_mul), .tag_Ra_mul(tag_Ra_mul), .tag_Rb_mul(tag_Rb_mul),
    .tag_PRF_mul_out(tag_PRF_mul_out), .tag_ROB_mul_out(tag_ROB_mul_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vd;
    logic        mul;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        rdy_a;
    logic        rdy_b;
    logic [4:0]  prf;
    logic [3:0]  rob;
    logic        ff;
    logic        fb;
    logic        wa;
    logic [4:0]  wat;
    logic        wm;
    logic [4:0]  wmt;
    logic [19:0] e_add;
    logic [19:0] e_mul;
    logic        e_full;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic logic [19:0] ex(input logic v, input logic [4:0] ra,
                                     input logic [4:0] rb, input logic [4:0] prf,
                                     input logic [3:0] rob);
    return {v, ra, rb, prf, rob};
  endfunction

  function automatic logic [40:0] outs();
    return {valid_add, tag_Ra_add, tag_Rb_add, tag_PRF_add_out, tag_ROB_add_out,
            valid_mul, tag_Ra_mul, tag_Rb_mul, tag_PRF_mul_out, tag_ROB_mul_out,
            full_IQ};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    valid_dispatch = 0; op_mul = 0; tag_Ra_in = 0; tag_Rb_in = 0;
    rdy_a_in = 0; rdy_b_in = 0; tag_PRF_in = 0; tag_ROB_in = 0;
    freeze_front = 0; freeze_back = 0;
    valid_Result_add = 0; tag_PRF_add = 0; valid_Result_mul = 0; tag_PRF_mul = 0;
  endtask

  task automatic dsp(input logic mul, input logic [4:0] ra, input logic [4:0] rb,
                     input logic ry_a, input logic ry_b, input logic [4:0] prf,
                     input logic [3:0] rob);
    valid_dispatch = 1; op_mul = mul; tag_Ra_in = ra; tag_Rb_in = rb;
    rdy_a_in = ry_a; rdy_b_in = ry_b; tag_PRF_in = prf; tag_ROB_in = rob;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [19:0] ha, hm, ha2, hm2, ha3, hm3;

  initial begin
    ha  = ex(0, 3, 4, 9, 2);
    hm  = ex(0, 5, 6, 10, 3);
    ha2 = ex(0, 7, 8, 11, 1);
    ha3 = ex(0, 20, 3, 13, 4);
    hm2 = ex(0, 21, 4, 14, 5);
    hm3 = ex(0, 22, 22, 16, 7);
    //            vd mul ra  rb ry_a ry_b prf rob ff fb wa wat wm wmt  e_add  e_mul  full
    vecs[0]  = '{1, 0, 3,  4,  1, 1, 9,  2, 0, 0, 0, 0,  0, 0,  ex(0,0,0,0,0), ex(0,0,0,0,0), 0};
    vecs[1]  = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  ex(1,3,4,9,2), ex(0,0,0,0,0), 0};
    vecs[2]  = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  ha, ex(0,0,0,0,0), 0};
    vecs[3]  = '{1, 1, 5,  6,  0, 1, 10, 3, 0, 0, 0, 0,  0, 0,  ha, ex(0,0,0,0,0), 0};
    vecs[4]  = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  ha, ex(0,0,0,0,0), 0};
    vecs[5]  = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  ha, ex(0,0,0,0,0), 0};
    vecs[6]  = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  ha, ex(0,0,0,0,0), 0};
    vecs[7]  = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 1, 5,  0, 0,  ha, ex(0,0,0,0,0), 0};
    vecs[8]  = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  ha, ex(1,5,6,10,3), 0};
    vecs[9]  = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  ha, hm, 0};
    vecs[10] = '{1, 0, 7,  8,  0, 1, 11, 1, 0, 0, 0, 0,  0, 0,  ha, hm, 0};
    vecs[11] = '{1, 0, 1,  2,  1, 1, 12, 2, 0, 0, 0, 0,  0, 0,  ha, hm, 0};
    vecs[12] = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 1, 7,  0, 0,  ex(1,1,2,12,2), hm, 0};
    vecs[13] = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  ex(1,7,8,11,1), hm, 0};
    vecs[14] = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  ha2, hm, 0};
    vecs[15] = '{1, 0, 20, 3,  0, 1, 13, 4, 0, 0, 0, 0,  0, 0,  ha2, hm, 0};
    vecs[16] = '{1, 1, 21, 4,  0, 1, 14, 5, 0, 0, 0, 0,  0, 0,  ha2, hm, 0};
    vecs[17] = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 1, 20, 1, 21, ha2, hm, 0};
    vecs[18] = '{1, 0, 22, 5,  0, 1, 15, 6, 0, 0, 0, 0,  0, 0,  ex(1,20,3,13,4), ex(1,21,4,14,5), 0};
    vecs[19] = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  ha3, hm2, 0};
    vecs[20] = '{1, 1, 22, 22, 0, 0, 16, 7, 0, 0, 1, 22, 0, 0,  ha3, hm2, 0};
    vecs[21] = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  ex(1,22,5,15,6), ex(1,22,22,16,7), 0};
    vecs[22] = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  ex(0,22,5,15,6), hm3, 0};
    vecs[23] = '{1, 0, 1,  1,  1, 1, 1,  1, 1, 0, 0, 0,  0, 0,  ex(0,22,5,15,6), hm3, 0};
    vecs[24] = '{0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  ex(0,22,5,15,6), hm3, 0};

    idle();
    rst = 1'b0;
    #12;
    chk("reset_async", 64'(outs()), 64'(0));
    @(negedge clk);
    @(negedge clk);
    chk("reset_held", 64'(outs()), 64'(0));
    rst = 1'b1;
    step();

    // Table: apply one vector per edge, compare the full output bundle.
    for (int i = 0; i < NV; i++) begin
      valid_dispatch = vecs[i].vd;   op_mul = vecs[i].mul;
      tag_Ra_in = vecs[i].ra;        tag_Rb_in = vecs[i].rb;
      rdy_a_in = vecs[i].rdy_a;      rdy_b_in = vecs[i].rdy_b;
      tag_PRF_in = vecs[i].prf;      tag_ROB_in = vecs[i].rob;
      freeze_front = vecs[i].ff;     freeze_back = vecs[i].fb;
      valid_Result_add = vecs[i].wa; tag_PRF_add = vecs[i].wat;
      valid_Result_mul = vecs[i].wm; tag_PRF_mul = vecs[i].wmt;
      step();
      chk($sformatf("vec%0d", i), 64'(outs()),
          64'({vecs[i].e_add, vecs[i].e_mul, vecs[i].e_full}));
    end
    idle();

    // Fill with eight adds waiting on tag 30.
    for (int i = 0; i < 8; i++) begin
      dsp(0, 30, 0, 0, 1, 5'(i), 4'(i));
      step();
      chk($sformatf("fill_full%0d", i), 64'(full_IQ), 64'(i == 7));
    end
    // Ninth dispatch is ready; if wrongly accepted it would issue.
    dsp(0, 1, 1, 1, 1, 31, 15);
    step();
    idle();
    chk("full_refuse", 64'({full_IQ, valid_add}), 64'(2'b10));
    step();
    chk("full_no_issue", 64'({full_IQ, valid_add}), 64'(2'b10));
    valid_Result_add = 1; tag_PRF_add = 30;
    step();
    idle();
    chk("full_wake_edge", 64'({full_IQ, valid_add}), 64'(2'b10));
    step();
    chk("full_first_issue", 64'({full_IQ, valid_add, tag_ROB_add_out}), 64'({1'b0, 1'b1, 4'd0}));
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("drain%0d", i), 64'({valid_add, tag_ROB_add_out}), 64'({1'b1, 4'(i)}));
    end
    step();
    chk("drain_empty", 64'({full_IQ, valid_add}), 64'(2'b00));

    // Freeze: X issues, then freeze_back holds X while Z is dispatched.
    dsp(0, 1, 1, 1, 1, 1, 1);
    step();
    dsp(0, 2, 2, 1, 1, 2, 2);
    step();
    chk("frz_x", 64'({valid_add, tag_ROB_add_out}), 64'({1'b1, 4'd1}));
    dsp(0, 3, 3, 1, 1, 3, 3);
    freeze_back = 1;
    step();
    idle();
    freeze_back = 1;
    chk("frz_hold1", 64'({valid_add, tag_ROB_add_out}), 64'({1'b1, 4'd1}));
    step();
    chk("frz_hold2", 64'({valid_add, tag_ROB_add_out}), 64'({1'b1, 4'd1}));
    freeze_back = 0;
    step();
    chk("frz_y", 64'({valid_add, tag_ROB_add_out}), 64'({1'b1, 4'd2}));
    step();
    chk("frz_z", 64'({valid_add, tag_ROB_add_out}), 64'({1'b1, 4'd3}));
    step();
    chk("frz_empty", 64'(valid_add), 64'(0));

    // Mid-stream reset: outputs clear without a clock edge; no replay.
    dsp(0, 1, 1, 1, 1, 4, 4);
    step();
    dsp(1, 1, 1, 1, 1, 5, 5);
    step();
    chk("rst_pre_add", 64'({valid_add, tag_ROB_add_out}), 64'({1'b1, 4'd4}));
    dsp(0, 9, 1, 0, 1, 6, 6);
    step();
    idle();
    chk("rst_pre_mul", 64'({valid_mul, tag_ROB_mul_out}), 64'({1'b1, 4'd5}));
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid", 64'({valid_add, valid_mul, tag_ROB_mul_out, full_IQ}), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    valid_Result_add = 1; tag_PRF_add = 9;
    step();
    idle();
    step();
    chk("rst_no_replay1", 64'({valid_add, valid_mul}), 64'(0));
    step();
    chk("rst_no_replay2", 64'({valid_add, valid_mul, full_IQ}), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
